// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap controller: state encoding, trap-type codes
// and the local-register numbers used to save the trapped PC/nPC.
package trap_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ENTER    = 3'd1,
      SAVE_PC  = 3'd2,
      SAVE_NPC = 3'd3,
      VECTOR   = 3'd4,
      ERROR    = 3'd5
   } trap_state_e;

   localparam logic [7:0] TT_INSTR_ACCESS  = 8'h01;
   localparam logic [7:0] TT_PRIVILEGED    = 8'h03;
   localparam logic [7:0] TT_ILLEGAL       = 8'h02;
   localparam logic [7:0] TT_FP_DISABLED   = 8'h04;
   localparam logic [7:0] TT_WIN_OVERFLOW  = 8'h05;
   localparam logic [7:0] TT_WIN_UNDERFLOW = 8'h06;
   localparam logic [7:0] TT_MEM_UNALIGNED = 8'h07;
   localparam logic [7:0] TT_DATA_ACCESS   = 8'h09;
   localparam logic [7:0] TT_TAG_OVERFLOW  = 8'h0A;

   localparam logic [7:0] TT_TICC_BASE = 8'h80;
   localparam logic [7:0] TT_IRQ_BASE  = 8'h10;

   localparam logic [4:0] RF_ADDR_PC  = 5'd17;
   localparam logic [4:0] RF_ADDR_NPC = 5'd18;

   // Maps an exception source index (bit 0 = highest priority) to its trap type.
   function automatic logic [7:0] excTrapType(input int idx);
      logic [7:0] code;
      case (idx)
         0:       code = TT_INSTR_ACCESS;
         1:       code = TT_PRIVILEGED;
         2:       code = TT_ILLEGAL;
         3:       code = TT_FP_DISABLED;
         4:       code = TT_WIN_OVERFLOW;
         5:       code = TT_WIN_UNDERFLOW;
         6:       code = TT_MEM_UNALIGNED;
         7:       code = TT_DATA_ACCESS;
         8:       code = TT_TAG_OVERFLOW;
         default: code = 8'h00;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Combinational trap priority encoder: synchronous exceptions, then trap
// instructions, then maskable interrupts.
module trap_prio_enc
   import trap_ctrl_pkg::*;
#(
   parameter int NEXC = 9
) (
   input  logic [NEXC-1:0] exc_req_i,
   input  logic            ticc_req_i,
   input  logic [6:0]      ticc_num_i,
   input  logic [3:0]      irl_i,
   input  logic            psr_et_i,
   input  logic [3:0]      psr_pil_i,
   output logic            valid_o,
   output logic            sync_o,
   output logic [7:0]      tt_o
);

   logic excHit;
   logic irqHit;
   int   excIdx;

   // Scanning downward leaves the lowest set index as the winner.
   always_comb begin
      excHit = 1'b0;
      excIdx = 0;
      for (int i = NEXC - 1; i >= 0; i--) begin
         if (exc_req_i[i]) begin
            excHit = 1'b1;
            excIdx = i;
         end
      end
   end

   // Level 15 is non-maskable relative to PIL; all interrupts need ET set.
   assign irqHit = psr_et_i && ((irl_i == 4'd15) || (irl_i > psr_pil_i));

   always_comb begin
      valid_o = excHit || ticc_req_i || irqHit;
      sync_o  = excHit || ticc_req_i;
      tt_o    = 8'h00;
      if (excHit) begin
         tt_o = excTrapType(excIdx);
      end else if (ticc_req_i) begin
         tt_o = TT_TICC_BASE + {1'b0, ticc_num_i};
      end else if (irqHit) begin
         tt_o = TT_IRQ_BASE + {4'b0000, irl_i};
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry sequencer: picks the winning trap, updates the PSR, saves PC/nPC
// to r17/r18 and vectors through the trap-base adder, or halts in error mode.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int NEXC = 9,
   parameter int NWIN = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [NEXC-1:0] exc_req_i,
   input  logic            ticc_req_i,
   input  logic [6:0]      ticc_num_i,
   input  logic [3:0]      irl_i,
   input  logic            psr_et_i,
   input  logic            psr_s_i,
   input  logic [3:0]      psr_pil_i,
   input  logic [4:0]      psr_cwp_i,
   input  logic [31:0]     pc_i,
   input  logic [31:0]     npc_i,
   output logic [7:0]      tt_o,
   output logic            tb_sel_o,
   output logic            flush_o,
   output logic            pc_load_o,
   output logic            psr_we_o,
   output logic            new_s_o,
   output logic            new_ps_o,
   output logic            new_et_o,
   output logic [4:0]      new_cwp_o,
   output logic            rf_we_o,
   output logic [4:0]      rf_waddr_o,
   output logic [31:0]     rf_wdata_o,
   output logic            busy_o,
   output logic            error_mode_o
);

   trap_state_e state_q, state_d;

   logic [7:0]  tt_q;
   logic [31:0] savedPc_q;
   logic [31:0] savedNpc_q;
   logic        savedS_q;
   logic [4:0]  newCwp_q;

   logic        trapValid;
   logic        trapSync;
   logic [7:0]  trapTt;
   logic        captureEn;
   logic [4:0]  cwpDec;

   trap_prio_enc #(
      .NEXC(NEXC)
   ) u_prio_enc (
      .exc_req_i (exc_req_i),
      .ticc_req_i(ticc_req_i),
      .ticc_num_i(ticc_num_i),
      .irl_i     (irl_i),
      .psr_et_i  (psr_et_i),
      .psr_pil_i (psr_pil_i),
      .valid_o   (trapValid),
      .sync_o    (trapSync),
      .tt_o      (trapTt)
   );

   assign captureEn = (state_q == IDLE) && trapValid;
   assign cwpDec    = (psr_cwp_i == 5'd0) ? 5'(NWIN - 1) : (psr_cwp_i - 5'd1);

   // A synchronous trap while traps are disabled has nowhere to go.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (trapValid) begin
               state_d = (trapSync && !psr_et_i) ? ERROR : ENTER;
            end
         end
         ENTER:    state_d = SAVE_PC;
         SAVE_PC:  state_d = SAVE_NPC;
         SAVE_NPC: state_d = VECTOR;
         VECTOR:   state_d = IDLE;
         ERROR:    state_d = ERROR;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         tt_q       <= 8'h00;
         savedPc_q  <= 32'h0;
         savedNpc_q <= 32'h0;
         savedS_q   <= 1'b0;
         newCwp_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         if (captureEn) begin
            tt_q       <= trapTt;
            savedPc_q  <= pc_i;
            savedNpc_q <= npc_i;
            savedS_q   <= psr_s_i;
            newCwp_q   <= cwpDec;
         end
      end
   end

   // Every strobe is a pure function of the registered state.
   always_comb begin
      tb_sel_o     = 1'b0;
      flush_o      = 1'b0;
      pc_load_o    = 1'b0;
      psr_we_o     = 1'b0;
      new_s_o      = 1'b0;
      new_ps_o     = 1'b0;
      new_et_o     = 1'b0;
      new_cwp_o    = 5'd0;
      rf_we_o      = 1'b0;
      rf_waddr_o   = 5'd0;
      rf_wdata_o   = 32'h0;
      busy_o       = 1'b0;
      error_mode_o = 1'b0;
      case (state_q)
         ENTER: begin
            busy_o    = 1'b1;
            flush_o   = 1'b1;
            psr_we_o  = 1'b1;
            new_s_o   = 1'b1;
            new_ps_o  = savedS_q;
            new_et_o  = 1'b0;
            new_cwp_o = newCwp_q;
         end
         SAVE_PC: begin
            busy_o     = 1'b1;
            rf_we_o    = 1'b1;
            rf_waddr_o = RF_ADDR_PC;
            rf_wdata_o = savedPc_q;
         end
         SAVE_NPC: begin
            busy_o     = 1'b1;
            rf_we_o    = 1'b1;
            rf_waddr_o = RF_ADDR_NPC;
            rf_wdata_o = savedNpc_q;
         end
         VECTOR: begin
            busy_o    = 1'b1;
            tb_sel_o  = 1'b1;
            pc_load_o = 1'b1;
         end
         ERROR: begin
            flush_o      = 1'b1;
            error_mode_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign tt_o = tt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed trap scenarios plus randomized
// traffic compared every cycle against a cycle-offset reference model.
module tb_trap_ctrl;

   localparam int NEXC = 9;
   localparam int NWIN = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NEXC-1:0] exc_req;
   logic            ticc_req;
   logic [6:0]      ticc_num;
   logic [3:0]      irl;
   logic            psr_et;
   logic            psr_s;
   logic [3:0]      psr_pil;
   logic [4:0]      psr_cwp;
   logic [31:0]     pc;
   logic [31:0]     npc;
   logic [7:0]      tt;
   logic            tb_sel;
   logic            flush;
   logic            pc_load;
   logic            psr_we;
   logic            new_s;
   logic            new_ps;
   logic            new_et;
   logic [4:0]      new_cwp;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [31:0]     rf_wdata;
   logic            busy;
   logic            error_mode;

   always #5 clk = ~clk;

   trap_ctrl #(
      .NEXC(NEXC),
      .NWIN(NWIN)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .exc_req_i   (exc_req),
      .ticc_req_i  (ticc_req),
      .ticc_num_i  (ticc_num),
      .irl_i       (irl),
      .psr_et_i    (psr_et),
      .psr_s_i     (psr_s),
      .psr_pil_i   (psr_pil),
      .psr_cwp_i   (psr_cwp),
      .pc_i        (pc),
      .npc_i       (npc),
      .tt_o        (tt),
      .tb_sel_o    (tb_sel),
      .flush_o     (flush),
      .pc_load_o   (pc_load),
      .psr_we_o    (psr_we),
      .new_s_o     (new_s),
      .new_ps_o    (new_ps),
      .new_et_o    (new_et),
      .new_cwp_o   (new_cwp),
      .rf_we_o     (rf_we),
      .rf_waddr_o  (rf_waddr),
      .rf_wdata_o  (rf_wdata),
      .busy_o      (busy),
      .error_mode_o(error_mode)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: a trap occupies the four cycles starting at mStart.
   int          mStart = -100;
   bit          mErr   = 1'b0;
   logic [7:0]  mTt    = 8'h00;
   logic [31:0] mPc    = 32'h0;
   logic [31:0] mNpc   = 32'h0;
   logic        mS     = 1'b0;
   logic [4:0]  mCwp   = 5'd0;
   logic [7:0]  excTt [NEXC] = '{8'h01, 8'h03, 8'h02, 8'h04, 8'h05,
                                 8'h06, 8'h07, 8'h09, 8'h0A};

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [NEXC-1:0] e, input logic tr,
                                input logic [6:0] tn, input logic [3:0] il,
                                input logic et, input logic s,
                                input logic [3:0] pil, input logic [4:0] cwp,
                                input logic [31:0] pcv, input logic [31:0] npcv);
      exc_req  = e;
      ticc_req = tr;
      ticc_num = tn;
      irl      = il;
      psr_et   = et;
      psr_s    = s;
      psr_pil  = pil;
      psr_cwp  = cwp;
      pc       = pcv;
      npc      = npcv;
   endtask

   task automatic quietInputs();
      applyStimulus('0, 1'b0, 7'h00, 4'd0, 1'b1, 1'b0, 4'd0, 5'd1,
                    32'hDEAD_BEEF, 32'hCAFE_F00D);
   endtask

   // Predicts the effect of the coming rising edge from the applied inputs.
   task automatic modelStep();
      int         p;
      bit         found;
      logic [7:0] t;
      p     = cyc - mStart;
      found = 1'b0;
      t     = 8'h00;
      if (!rst_n) begin
         mErr   = 1'b0;
         mStart = -100;
         mTt    = 8'h00;
         mPc    = 32'h0;
         mNpc   = 32'h0;
         return;
      end
      if (mErr || (p >= 0 && p <= 3)) return;
      for (int i = 0; i < NEXC; i++) begin
         if (!found && exc_req[i]) begin
            found = 1'b1;
            t     = excTt[i];
         end
      end
      if (!found && ticc_req) begin
         found = 1'b1;
         t     = 8'h80 + {1'b0, ticc_num};
      end
      if (found && !psr_et) begin
         mErr = 1'b1;
         mTt  = t;
         return;
      end
      if (!found && psr_et && (irl == 4'd15 || irl > psr_pil)) begin
         found = 1'b1;
         t     = 8'h10 + {4'd0, irl};
      end
      if (found) begin
         mStart = cyc + 1;
         mTt    = t;
         mPc    = pc;
         mNpc   = npc;
         mS     = psr_s;
         mCwp   = 5'((int'(psr_cwp) + NWIN - 1) % NWIN);
      end
   endtask

   task automatic compareAll();
      int p;
      bit act;
      p   = cyc - mStart;
      act = !mErr && p >= 0 && p <= 3;
      checkOutput("tt", 32'(tt), 32'(mTt));
      checkOutput("flush", 32'(flush), 32'(mErr || (act && p == 0)));
      checkOutput("psr_we", 32'(psr_we), 32'(act && p == 0));
      checkOutput("rf_we", 32'(rf_we), 32'(act && (p == 1 || p == 2)));
      checkOutput("tb_sel", 32'(tb_sel), 32'(act && p == 3));
      checkOutput("pc_load", 32'(pc_load), 32'(act && p == 3));
      checkOutput("busy", 32'(busy), 32'(act));
      checkOutput("error_mode", 32'(error_mode), 32'(mErr));
      if (act && p == 0) begin
         checkOutput("new_s", 32'(new_s), 32'h1);
         checkOutput("new_ps", 32'(new_ps), 32'(mS));
         checkOutput("new_et", 32'(new_et), 32'h0);
         checkOutput("new_cwp", 32'(new_cwp), 32'(mCwp));
      end
      if (act && p == 1) begin
         checkOutput("rf_waddr", 32'(rf_waddr), 32'd17);
         checkOutput("rf_wdata", rf_wdata, mPc);
      end
      if (act && p == 2) begin
         checkOutput("rf_waddr", 32'(rf_waddr), 32'd18);
         checkOutput("rf_wdata", rf_wdata, mNpc);
      end
   endtask

   task automatic tick();
      modelStep();
      @(negedge clk);
      cyc++;
      compareAll();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [NEXC-1:0] e;
      rst_n = 1'b0;
      quietInputs();
      tick();
      tick();
      checkOutput("rst_tt", 32'(tt), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_error_mode", 32'(error_mode), 32'h0);
      rst_n = 1'b1;
      tick();

      // Illegal instruction with full four-cycle sequence.
      applyStimulus(9'h004, 1'b0, 7'h00, 4'd0, 1'b1, 1'b0, 4'd0, 5'd3,
                    32'h0000_0040, 32'h0000_0044);
      tick();
      checkOutput("d1_tt", 32'(tt), 32'h02);
      checkOutput("d1_model_tt", 32'(mTt), 32'h02);
      checkOutput("d1_new_cwp", 32'(new_cwp), 32'd2);
      checkOutput("d1_flush", 32'(flush), 32'h1);
      quietInputs();
      tick();
      checkOutput("d1_r17_addr", 32'(rf_waddr), 32'd17);
      checkOutput("d1_r17_data", rf_wdata, 32'h40);
      tick();
      checkOutput("d1_r18_addr", 32'(rf_waddr), 32'd18);
      checkOutput("d1_r18_data", rf_wdata, 32'h44);
      checkOutput("d1_early_pc_load", 32'(pc_load), 32'h0);
      tick();
      checkOutput("d1_pc_load", 32'(pc_load), 32'h1);
      tick();
      checkOutput("d1_pc_load_done", 32'(pc_load), 32'h0);
      checkOutput("d1_busy_done", 32'(busy), 32'h0);

      // Lowest exception index beats a simultaneous trap instruction.
      applyStimulus(9'h041, 1'b1, 7'h05, 4'd0, 1'b1, 1'b0, 4'd0, 5'd4,
                    32'h100, 32'h104);
      tick();
      checkOutput("d2_tt", 32'(tt), 32'h01);
      quietInputs();
      repeat (4) tick();

      // Interrupt level comparison against PIL.
      applyStimulus('0, 1'b0, 7'h00, 4'd5, 1'b1, 1'b0, 4'd4, 5'd2,
                    32'h200, 32'h204);
      tick();
      checkOutput("d3_tt_irl5", 32'(tt), 32'h15);
      quietInputs();
      repeat (4) tick();
      applyStimulus('0, 1'b0, 7'h00, 4'd4, 1'b1, 1'b0, 4'd4, 5'd2,
                    32'h300, 32'h304);
      tick();
      checkOutput("d3_no_trap_busy", 32'(busy), 32'h0);
      checkOutput("d3_no_trap_flush", 32'(flush), 32'h0);
      applyStimulus('0, 1'b0, 7'h00, 4'd15, 1'b1, 1'b0, 4'd15, 5'd2,
                    32'h400, 32'h404);
      tick();
      checkOutput("d3_tt_irl15", 32'(tt), 32'h1F);
      quietInputs();
      repeat (4) tick();

      // Trap instruction with CWP wrapping from 0.
      applyStimulus('0, 1'b1, 7'h10, 4'd0, 1'b1, 1'b1, 4'd0, 5'd0,
                    32'h500, 32'h504);
      tick();
      checkOutput("d4_tt", 32'(tt), 32'h90);
      checkOutput("d4_new_cwp", 32'(new_cwp), 32'd7);
      checkOutput("d4_model_cwp", 32'(mCwp), 32'd7);
      checkOutput("d4_new_ps", 32'(new_ps), 32'h1);
      checkOutput("d4_new_et", 32'(new_et), 32'h0);
      quietInputs();
      repeat (4) tick();

      // Synchronous trap with ET clear: sticky error mode until reset.
      applyStimulus(9'h010, 1'b0, 7'h00, 4'd0, 1'b0, 1'b0, 4'd0, 5'd1,
                    32'h600, 32'h604);
      tick();
      checkOutput("d5_error_mode", 32'(error_mode), 32'h1);
      applyStimulus(9'h001, 1'b1, 7'h00, 4'd15, 1'b1, 1'b0, 4'd0, 5'd1,
                    32'h700, 32'h704);
      repeat (3) tick();
      checkOutput("d5_sticky", 32'(error_mode), 32'h1);
      checkOutput("d5_flush_held", 32'(flush), 32'h1);
      quietInputs();
      rst_n = 1'b0;
      tick();
      checkOutput("d5_reset_error_mode", 32'(error_mode), 32'h0);
      rst_n = 1'b1;
      tick();

      // Reset during SAVE_PC aborts; a later trap runs the whole sequence.
      applyStimulus(9'h004, 1'b0, 7'h00, 4'd0, 1'b1, 1'b0, 4'd0, 5'd3,
                    32'h800, 32'h804);
      tick();
      quietInputs();
      tick();
      checkOutput("d6_r17_addr", 32'(rf_waddr), 32'd17);
      rst_n = 1'b0;
      tick();
      checkOutput("d6_no_r18", 32'(rf_we), 32'h0);
      rst_n = 1'b1;
      repeat (3) tick();
      applyStimulus(9'h100, 1'b0, 7'h00, 4'd0, 1'b1, 1'b0, 4'd0, 5'd5,
                    32'h900, 32'h904);
      tick();
      checkOutput("d6_tt", 32'(tt), 32'h0A);
      quietInputs();
      repeat (3) tick();
      checkOutput("d6_pc_load", 32'(pc_load), 32'h1);
      tick();

      // Randomized traffic checked cycle by cycle against the model.
      for (int n = 0; n < 3000; n++) begin
         e = '0;
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 2) == 0) e = NEXC'($urandom);
            else e[$urandom_range(0, NEXC - 1)] = 1'b1;
         end
         applyStimulus(e, ($urandom_range(0, 7) == 0), 7'($urandom),
                       4'($urandom), ($urandom_range(0, 15) != 0),
                       1'($urandom), 4'($urandom),
                       5'($urandom_range(0, NWIN - 1)), $urandom, $urandom);
         rst_n = ($urandom_range(0, 49) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter NEXC, default 9, number of synchronous exception sources; bit 0 highest priority.
REQ-002 Parameter NWIN, default 8, number of register windows; used for CWP wrap.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 exc_req  in  NEXC  pending exceptions: b0 instr_access tt=0x01, b1 privileged 0x03, b2 illegal 0x02, b3 fp_disabled 0x04, b4 win_overflow 0x05, b5 win_underflow 0x06, b6 mem_unaligned 0x07, b7 data_access 0x09, b8 tag_overflow 0x0A.
REQ-006 ticc_req  in  1 ; ticc_num  in  7  trap instruction; tt=0x80+ticc_num.
REQ-007 irl  in  4  external interrupt level; 0 = none.
REQ-008 psr_et, psr_s  in  1 each; psr_pil  in  4 ; psr_cwp  in  5  current PSR fields.
REQ-009 pc, npc  in  32 each  addresses of trapped instruction.
REQ-010 tt  out  8  latched trap type, feeds trap-base adder tt field.
REQ-011 tb_sel  out  1  select strobe to trap-base adder; PC mux takes {TBA,tt,0000}.
REQ-012 flush  out  1  squash pipeline; pc_load  out  1  load PC from trap-base adder.
REQ-013 psr_we  out  1 ; new_s, new_ps, new_et  out  1 each ; new_cwp  out  5  PSR update.
REQ-014 rf_we  out  1 ; rf_waddr  out  5 ; rf_wdata  out  32  local-register save port.
REQ-015 busy  out  1 ; error_mode  out  1  sticky processor error state.

Function
REQ-016 States SHALL be IDLE, ENTER, SAVE_PC, SAVE_NPC, VECTOR, ERROR; one state per cycle outside IDLE/ERROR.
REQ-017 Trap condition in IDLE: any exc_req bit, or ticc_req, or (psr_et=1 and (irl=15 or irl>psr_pil)).
REQ-018 Priority: lowest set exc_req index > ticc_req > interrupt; tt latched at IDLE exit, held until next trap.
REQ-019 Interrupt tt SHALL be 0x10+irl; irl sampled only in IDLE; changes afterwards ignored.
REQ-020 Synchronous trap (exc/ticc) with psr_et=0: IDLE->ERROR; error_mode=1, flush=1 held; exit only via reset.
REQ-021 Interrupt with psr_et=0 SHALL be ignored (no state change).
REQ-022 IDLE->ENTER: flush=1, psr_we=1, new_s=1, new_ps=psr_s, new_et=0, new_cwp=(psr_cwp-1) mod NWIN (0 wraps to NWIN-1).
REQ-023 ENTER->SAVE_PC: rf_we=1, rf_waddr=17, rf_wdata=pc latched at detection.
REQ-024 SAVE_PC->SAVE_NPC: rf_we=1, rf_waddr=18, rf_wdata=npc latched at detection.
REQ-025 SAVE_NPC->VECTOR: tb_sel=1, pc_load=1 for exactly one cycle; VECTOR->IDLE.
REQ-026 Latency: detection cycle N, tb_sel/pc_load at N+4; busy=1 from N+1 through N+4.
REQ-027 New requests while busy SHALL be ignored; trap requests sampled again first IDLE cycle after VECTOR.
REQ-028 All strobes (flush, psr_we, rf_we, tb_sel, pc_load) SHALL be 0 in any cycle not listed above.

Reset
REQ-029 rst_n=0 at a clock edge: state=IDLE, tt=0, all strobes 0, busy=0, error_mode=0, latched pc/npc=0.
REQ-030 Reset mid-sequence SHALL abort with no further rf_we or pc_load pulses.

Structure
REQ-031 Shared package: state encoding, tt constants per exception, r17/r18 addresses, ticc base 0x80, interrupt base 0x10.
REQ-032 One sub-module trap_prio_enc: combinational priority encoder exc_req/ticc/irl -> valid, tt.

Verification
REQ-033 exc_req=0x004 (illegal), et=1, cwp=3, pc=0x40, npc=0x44 -> tt=0x02, new_cwp=2, r17<=0x40, r18<=0x44, pc_load at N+4.
REQ-034 exc_req=0x041 simultaneous with ticc_req=1 -> tt=0x01 (instr_access wins).
REQ-035 irl=5, pil=4, et=1 -> tt=0x15; irl=4, pil=4 -> no trap; irl=15, pil=15 -> tt=0x1F.
REQ-036 cwp=0, NWIN=8, ticc_num=0x10 -> tt=0x90, new_cwp=7, new_ps=old psr_s, new_et=0.
REQ-037 et=0, exc_req=0x010 -> ERROR, error_mode=1 sticky; rst_n=0 -> IDLE, error_mode=0.
REQ-038 rst_n=0 in SAVE_PC -> no r18 write, no pc_load; subsequent trap runs full sequence.
